// File: rtl/maxnet_feeder.sv
// -----------------------------------------------------------------------------
// maxnet_feeder
//
// Host-side sequencer for the 4-neuron maxnet datapath. It collects four
// activation words from an upstream stream, loads them into the datapath
// (init/write_reg), runs the datapath (start) until it reports a single
// surviving neuron (done), then offers the winner index to the host.
//
// Optional feature (compile-time macro):
//   MAXNET_FEEDER_TIMEOUT_EN - adds a RUN watchdog. After MAX_ITER RUN cycles
//   without a qualifying done, the result is emitted with res_err=1 and
//   res_index all-ones. Without the macro, res_err is tied low and RUN waits
//   for done indefinitely.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid, once raised by the producer, is held with stable data
// until that edge. Here in_valid/in_ready move activation words in, and
// res_valid/res_ready move the result out.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_data    activation stream, words in order x1,x2,x3,x4
//   in_ready            high in LOAD only
//   x1..x4              activations to datapath, stable from INIT until LOAD
//   init, write_reg     one-cycle pulses in INIT
//   start               high throughout RUN
//   done, max_index     datapath completion and winner index
//   res_valid/res_ready result handshake; res_index, res_err result payload
//   busy                high in INIT, RUN, RESULT
//   dbg_state           current FSM state (0=LOAD 1=INIT 2=RUN 3=RESULT)
// -----------------------------------------------------------------------------
module maxnet_feeder #(
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 16,
    parameter int SETTLE   = 2,
    parameter int MAX_ITER = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic [DATA_W-1:0] x4,
    output logic              init,
    output logic              write_reg,
    output logic              start,
    input  logic              done,
    input  logic [IDX_W-1:0]  max_index,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_index,
    output logic              res_err,
    input  logic              res_ready,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // The iteration counter must reach both SETTLE and MAX_ITER-1.
    localparam int CNT_MAX = (MAX_ITER > SETTLE) ? MAX_ITER : SETTLE;
    localparam int ITER_W  = ($clog2(CNT_MAX + 1) > 0) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_INIT   = 2'd1,
        S_RUN    = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t              state_q;
    logic [1:0]          wr_ptr_q;
    logic [ITER_W-1:0]   iter_q;
    logic [DATA_W-1:0]   x1_q, x2_q, x3_q, x4_q;
    logic [IDX_W-1:0]    res_index_q;
    logic                done_ok;

    // done only counts once the datapath pipeline has filled.
    assign done_ok = done && (iter_q >= ITER_W'(SETTLE));

`ifdef MAXNET_FEEDER_TIMEOUT_EN
    logic res_err_q;
    logic timeout;
    assign timeout = (iter_q == ITER_W'(MAX_ITER - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            wr_ptr_q    <= 2'd0;
            iter_q      <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            x4_q        <= '0;
            res_index_q <= '0;
`ifdef MAXNET_FEEDER_TIMEOUT_EN
            res_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        case (wr_ptr_q)
                            2'd0:    x1_q <= in_data;
                            2'd1:    x2_q <= in_data;
                            2'd2:    x3_q <= in_data;
                            default: x4_q <= in_data;
                        endcase
                        // 2-bit pointer wraps to 0 after the fourth word.
                        wr_ptr_q <= wr_ptr_q + 2'd1;
                        if (wr_ptr_q == 2'd3) begin
                            state_q <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    iter_q  <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (iter_q != '1) begin
                        iter_q <= iter_q + 1'b1;
                    end
                    // done has priority over the watchdog on the same cycle.
                    if (done_ok) begin
                        res_index_q <= max_index;
`ifdef MAXNET_FEEDER_TIMEOUT_EN
                        res_err_q   <= 1'b0;
`endif
                        state_q     <= S_RESULT;
                    end
`ifdef MAXNET_FEEDER_TIMEOUT_EN
                    else if (timeout) begin
                        res_index_q <= '1;
                        res_err_q   <= 1'b1;
                        state_q     <= S_RESULT;
                    end
`endif
                end
                S_RESULT: begin
                    if (res_ready) begin
                        state_q <= S_LOAD;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // Control outputs are pure decodes of the state register.
    assign in_ready  = (state_q == S_LOAD);
    assign init      = (state_q == S_INIT);
    assign write_reg = (state_q == S_INIT);
    assign start     = (state_q == S_RUN);
    assign res_valid = (state_q == S_RESULT);
    assign busy      = (state_q != S_LOAD);
    assign dbg_state = state_q;

    assign x1        = x1_q;
    assign x2        = x2_q;
    assign x3        = x3_q;
    assign x4        = x4_q;
    assign res_index = res_index_q;

`ifdef MAXNET_FEEDER_TIMEOUT_EN
    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_feeder.sv
module tb_maxnet_feeder;

  localparam int DW       = 32;
  localparam int IW       = 16;
  localparam int SETTLE   = 2;
  localparam int MAX_ITER = 16;
  localparam int PAT_N    = 300;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] x1, x2, x3, x4;
  logic          init, write_reg, start;
  logic          done;
  logic [IW-1:0] max_index;
  logic          res_valid;
  logic [IW-1:0] res_index;
  logic          res_err;
  logic          res_ready;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  maxnet_feeder #(
    .DATA_W(DW), .IDX_W(IW), .SETTLE(SETTLE), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .init(init), .write_reg(write_reg), .start(start),
    .done(done), .max_index(max_index),
    .res_valid(res_valid), .res_index(res_index), .res_err(res_err),
    .res_ready(res_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            total = 0;
  int            bad   = 0;
  logic [IW-1:0] exp_q[$];
  logic [DW-1:0] words[4];
  bit            done_pat[PAT_N];
  logic [IW-1:0] idx_pat[PAT_N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},   64'(dbg_state), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_x"},       {x1, x2} | {x3, x4}, 64'd0);
    check({tag, "_ctl"},     64'({init, write_reg, start, res_valid, res_err, busy}), 64'd0);
    check({tag, "_res_idx"}, 64'(res_index), 64'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic send_word(input logic [DW-1:0] d, input int gap_max);
    int n;
    int guard;
    n = $urandom_range(0, gap_max);
    repeat (n) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(negedge clk);
    end
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // One full transaction. target<0: datapath never raises a qualifying done.
  // abort_at>=0: reset is pulsed after that many RUN cycles.
  task automatic run_txn(input int gap_max, input int target, input logic [IW-1:0] idx,
                         input bit force_early, input int ready_delay, input int abort_at);
    int            end_k;
    int            run_len;
    logic          exp_err;
    logic [IW-1:0] exp_idx;
    logic [IW-1:0] got;

    // Datapath behaviour for this run, indexed by RUN cycle.
    for (int k = 0; k < PAT_N; k++) begin
      done_pat[k] = 1'b0;
      idx_pat[k]  = IW'($urandom);
    end
    for (int k = 0; k < SETTLE; k++) done_pat[k] = force_early ? 1'b1 : 1'(($urandom_range(0, 1)));
    if (target >= 0) begin
      done_pat[target] = 1'b1;
      idx_pat[target]  = idx;
    end

    // Reference: first done at or after SETTLE wins; watchdog fires on the
    // MAX_ITER-th RUN cycle when enabled.
    end_k   = -1;
    exp_err = 1'b0;
    exp_idx = '0;
    for (int k = 0; k < PAT_N; k++) begin
      if (done_pat[k] && k >= SETTLE) begin
        end_k   = k;
        exp_idx = idx_pat[k];
        break;
      end
`ifdef MAXNET_FEEDER_TIMEOUT_EN
      if (k == MAX_ITER - 1) begin
        end_k   = k;
        exp_err = 1'b1;
        exp_idx = '1;
        break;
      end
`endif
    end
    if (end_k >= 0) exp_q.push_back(exp_idx);

    for (int i = 0; i < 4; i++) send_word(words[i], gap_max);

    // INIT cycle
    check("init_pulse", 64'({init, write_reg, start}), 64'b110);
    check("init_ready", 64'({in_ready, busy}), 64'b01);
    check("init_x", {x1, x2}, {words[0], words[1]});
    check("init_x34", {x3, x4}, {words[2], words[3]});
    @(negedge clk);

    run_len = (end_k >= 0) ? end_k + 1 : 100;
    if (abort_at >= 0) run_len = abort_at;
    for (int k = 0; k < run_len; k++) begin
      check("run_ctl", 64'({start, init, res_valid, in_ready, busy}), 64'b10001);
      done      = done_pat[k];
      max_index = idx_pat[k];
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      @(negedge clk);
    end
    done     = 1'b0;
    in_valid = 1'b0;

    if (abort_at >= 0) begin
      pulse_reset();
      check_reset_vals("rst_run");
      if (end_k >= 0) void'(exp_q.pop_back());
      return;
    end
    if (end_k < 0) begin
      check("still_run", 64'({busy, start, res_valid}), 64'b110);
      pulse_reset();
      check_reset_vals("rst_norun");
      return;
    end

    // RESULT
    check("res_ctl", 64'({start, res_valid, in_ready, busy}), 64'b0101);
    check("res_err", 64'(res_err), 64'(exp_err));
    got = exp_q.pop_front();
    check("res_index", 64'(res_index), 64'(got));
    check("res_x", {x1, x2, x3, x4} == {words[0], words[1], words[2], words[3]}, 64'd1);
    res_ready = 1'b0;
    repeat (ready_delay) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      check("hold_valid", 64'({res_valid, in_ready}), 64'b10);
      check("hold_index", 64'(res_index), 64'(got));
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("after_hs", 64'({res_valid, in_ready, busy}), 64'b010);
    check("after_hs_x", {x1, x2, x3, x4} == {words[0], words[1], words[2], words[3]}, 64'd1);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++) words[i] = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    done = 1'b0; max_index = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    // Directed: 5,9,3,1 back to back, done on RUN cycle 6 with index 1.
    words[0] = 5; words[1] = 9; words[2] = 3; words[3] = 1;
    run_txn(0, 6, 16'd1, 1'b0, 0, -1);

    // Gapped input, early done forced on cycles 0 and 1, winner on cycle 4.
    rand_words();
    run_txn(1, 4, 16'd3, 1'b1, 2, -1);

    // Host stalls the result for 10 cycles.
    rand_words();
    run_txn(2, 5, 16'd2, 1'b0, 10, -1);

    // Randomized transactions.
    for (int t = 0; t < 8; t++) begin
      rand_words();
      run_txn(3, $urandom_range(SETTLE, 12), IW'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 4), -1);
    end

    // done on the last allowed cycle: done wins over the watchdog.
    rand_words();
    run_txn(0, MAX_ITER - 1, 16'h00A5, 1'b0, 1, -1);

    // No done at all: watchdog result, or still in RUN without the watchdog.
    rand_words();
    run_txn(0, -1, '0, 1'b1, 1, -1);

    // Reset after the second word, then a clean load from scratch.
    rand_words();
    send_word(words[0], 0);
    send_word(words[1], 0);
    pulse_reset();
    check_reset_vals("rst_load");
    rand_words();
    run_txn(0, 3, 16'd7, 1'b0, 0, -1);

    // Reset in the middle of RUN, then another full transaction.
    rand_words();
    run_txn(0, 9, 16'd1, 1'b0, 0, 5);
    rand_words();
    run_txn(1, 2, 16'd2, 1'b0, 0, -1);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
